// File: rtl/pps_conditioner.sv
// -----------------------------------------------------------------------------
// pps_conditioner
//   Cleans up the raw GPS 1PPS input before it drives clock_counter.one_pps.
//   The input is synchronised and deglitched. Each pulse interval is checked
//   against the nominal clk count. Lock is tracked, and when the GPS pulse is
//   lost a synthetic pulse is issued (holdover) on the grid of the last real
//   edge.
//
// Ports
//   clk        in   system clock (clock_counter domain)
//   rst        in   asynchronous, active-high reset
//   pps_in     in   raw GPS 1PPS, asynchronous to clk
//   pps_out    out  conditioned pulse, one clk wide
//   locked     out  high while in LOCKED (registered from state)
//   holdover   out  high while in HOLDOVER (registered from state)
//   ivl_valid  out  one-clk strobe: last_ivl was updated this cycle
//   last_ivl   out  clk count between the last two qualified edges
// -----------------------------------------------------------------------------
module pps_conditioner #(
   parameter int CNT_W    = 28,
   parameter int NOMINAL  = 26000000,
   parameter int TOL      = 2600,
   parameter int GLITCH   = 4,
   parameter int LOCK_CNT = 2,
   parameter int HOLD_MAX = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pps_in,
   output logic             pps_out,
   output logic             locked,
   output logic             holdover,
   output logic             ivl_valid,
   output logic [CNT_W-1:0] last_ivl
);

   localparam int GW = $clog2(GLITCH + 1);
   localparam int LW = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0] L_LO     = CNT_W'(NOMINAL - TOL);
   localparam logic [CNT_W-1:0] L_NOM    = CNT_W'(NOMINAL);
   localparam logic [CNT_W-1:0] L_HI     = CNT_W'(NOMINAL + TOL);
   localparam logic [CNT_W-1:0] L_TO     = CNT_W'(NOMINAL + TOL + 1);
   localparam logic [CNT_W-1:0] L_RELOAD = CNT_W'(TOL + 1);
   localparam logic [CNT_W-1:0] L_MAX    = '1;
   localparam logic [GW-1:0]    L_GLITCH_LAST = GW'(GLITCH - 1);
   localparam logic [LW-1:0]    L_LOCK_LAST   = LW'(LOCK_CNT - 1);
   localparam logic [7:0]       L_HOLD_MAX    = 8'(HOLD_MAX);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACQUIRE  = 2'd1,
      S_LOCKED   = 2'd2,
      S_HOLDOVER = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic             r_s1, r_s2, r_f;
   logic [GW-1:0]    r_gcnt;
   logic [CNT_W-1:0] r_ivl;
   logic [LW-1:0]    r_good;
   logic [7:0]       r_hold;
   logic             r_pps_out, r_locked, r_holdover, r_ivl_valid;
   logic [CNT_W-1:0] r_last_ivl;

   logic             w_q;
   logic             w_syn;
   logic             w_upd;
   logic             w_in_win;
   logic             w_early;
   logic [7:0]       w_hold_inc;

   // ---------------------------------------------------------------- input path
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_f    <= 1'b0;
         r_gcnt <= '0;
      end else begin
         r_s1 <= pps_in;
         r_s2 <= r_s1;
         // Count consecutive synced samples that disagree with the filtered level.
         if (r_s2 == r_f) begin
            r_gcnt <= '0;
         end else if (r_gcnt == L_GLITCH_LAST) begin
            r_f    <= r_s2;
            r_gcnt <= '0;
         end else begin
            r_gcnt <= r_gcnt + GW'(1);
         end
      end
   end

   // Qualified edge: asserted in the cycle before the filter rises, so that
   // every registered consequence lands on the same edge as the filter.
   assign w_q = r_s2 & ~r_f & (r_gcnt == L_GLITCH_LAST);

   assign w_in_win   = (r_ivl >= L_LO) && (r_ivl <= L_HI);
   assign w_early    = (r_ivl < L_LO);
   assign w_hold_inc = (r_hold == 8'hFF) ? 8'hFF : r_hold + 8'd1;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_q) w_next = S_ACQUIRE;
         end
         S_ACQUIRE: begin
            if (w_q) begin
               if (w_in_win && (r_good == L_LOCK_LAST)) w_next = S_LOCKED;
            end else if (r_ivl == L_TO) begin
               w_next = S_IDLE;
            end
         end
         S_LOCKED: begin
            if (w_q) begin
               if (w_early) w_next = S_ACQUIRE;
            end else if (w_syn) begin
               w_next = (HOLD_MAX <= 1) ? S_IDLE : S_HOLDOVER;
            end
         end
         S_HOLDOVER: begin
            if (w_q)                                    w_next = S_ACQUIRE;
            else if (w_syn && (w_hold_inc >= L_HOLD_MAX)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A real edge always wins over a synthetic pulse due in the same cycle.
   always_comb begin
      w_syn = 1'b0;
      w_upd = 1'b0;
      case (r_state)
         S_ACQUIRE:  w_upd = w_q;
         S_LOCKED: begin
            w_upd = w_q;
            w_syn = ~w_q & (r_ivl == L_HI);
         end
         S_HOLDOVER: begin
            w_upd = w_q;
            w_syn = ~w_q & (r_ivl == L_NOM);
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ivl       <= '0;
         r_good      <= '0;
         r_hold      <= '0;
         r_pps_out   <= 1'b0;
         r_ivl_valid <= 1'b0;
         r_last_ivl  <= '0;
         r_locked    <= 1'b0;
         r_holdover  <= 1'b0;
      end else begin
         // The first synthetic pulse fires TOL late; reloading TOL+1 puts the
         // following ones back on the nominal grid of the last real edge.
         if (w_next == S_IDLE)                          r_ivl <= '0;
         else if (w_q || (w_syn && r_state == S_HOLDOVER)) r_ivl <= CNT_W'(1);
         else if (w_syn)                                r_ivl <= L_RELOAD;
         else if (r_ivl != L_MAX)                       r_ivl <= r_ivl + CNT_W'(1);

         if (w_q && r_state == S_ACQUIRE) r_good <= w_in_win ? r_good + LW'(1) : '0;
         else if (w_q)                    r_good <= '0;

         if (w_q)        r_hold <= '0;
         else if (w_syn) r_hold <= (r_state == S_LOCKED) ? 8'd1 : w_hold_inc;

         r_pps_out   <= w_q | w_syn;
         r_ivl_valid <= w_upd;
         if (w_upd) r_last_ivl <= r_ivl;

         r_locked   <= (r_state == S_LOCKED);
         r_holdover <= (r_state == S_HOLDOVER);
      end
   end

   assign pps_out   = r_pps_out;
   assign locked    = r_locked;
   assign holdover  = r_holdover;
   assign ivl_valid = r_ivl_valid;
   assign last_ivl  = r_last_ivl;

endmodule

// File: tb/tb_pps_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pps_conditioner
//   Bench for pps_conditioner with NOMINAL=1000, TOL=10, GLITCH=4,
//   LOCK_CNT=2, HOLD_MAX=3. Every expected pps_out pulse is queued with the
//   cycle it must appear on; a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_pps_conditioner;

   localparam int CNT_W    = 28;
   localparam int NOMINAL  = 1000;
   localparam int TOL      = 10;
   localparam int GLITCH   = 4;
   localparam int LOCK_CNT = 2;
   localparam int HOLD_MAX = 3;
   localparam int LAT      = GLITCH + 1;   // first sampling edge -> pulse edge

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             pps_in = 1'b0;
   logic             pps_out, locked, holdover, ivl_valid;
   logic [CNT_W-1:0] last_ivl;

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int cyc;
      bit valid;
      int ivl;
   } exp_t;

   typedef struct {
      int offset;   // first sampling edge, relative to previous row
      int width;    // clks pps_in is held high
      bit pulse;    // a pps_out pulse is expected
      bit valid;    // ivl_valid expected with that pulse
      int ivl;      // expected last_ivl when valid
      bit lck;      // locked expected afterwards
      bit hold;     // holdover expected afterwards
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[14];

   pps_conditioner #(
      .CNT_W(CNT_W), .NOMINAL(NOMINAL), .TOL(TOL),
      .GLITCH(GLITCH), .LOCK_CNT(LOCK_CNT), .HOLD_MAX(HOLD_MAX)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pps_in   (pps_in),
      .pps_out  (pps_out),
      .locked   (locked),
      .holdover (holdover),
      .ivl_valid(ivl_valid),
      .last_ivl (last_ivl)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   // Leaves the caller 1 time unit after a rising edge.
   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pulse(input int start, input int width, input bit pulse,
                             input bit valid, input int ivl);
      exp_t e;
      if (pulse) begin
         e = '{start + LAT, valid, ivl};
         exp_q.push_back(e);
      end
      wait_cyc(start - 1);
      pps_in = 1'b1;
      wait_cyc(start + width - 1);
      pps_in = 1'b0;
   endtask

   task automatic expect_syn(input int c);
      exp_t e;
      e = '{c, 1'b0, 0};
      exp_q.push_back(e);
   endtask

   task automatic mon_step();
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         check("stale_expectation_cycle", cyc, exp_q[0].cyc);
         e = exp_q.pop_front();
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         check("pps_out", pps_out, 1);
         check("ivl_valid", ivl_valid, e.valid);
         if (e.valid) check("last_ivl", last_ivl, e.ivl);
      end else begin
         if (pps_out)   check("pps_out_unexpected", pps_out, 0);
         if (ivl_valid) check("ivl_valid_unexpected", ivl_valid, 0);
      end
   endtask

   initial begin
      int start;
      int q;
      int q2;

      vecs[0]  = '{20,   3,  1'b0, 1'b0, 0,    1'b0, 1'b0};  // 3-clk glitch, IDLE
      vecs[1]  = '{50,   20, 1'b1, 1'b0, 0,    1'b0, 1'b0};  // IDLE q: no ivl
      vecs[2]  = '{1000, 20, 1'b1, 1'b1, 1000, 1'b0, 1'b0};
      vecs[3]  = '{1005, 20, 1'b1, 1'b1, 1005, 1'b1, 1'b0};  // second in-window -> lock
      vecs[4]  = '{995,  20, 1'b1, 1'b1, 995,  1'b1, 1'b0};
      vecs[5]  = '{500,  20, 1'b1, 1'b1, 500,  1'b0, 1'b0};  // early -> ACQUIRE
      vecs[6]  = '{1000, 20, 1'b1, 1'b1, 1000, 1'b0, 1'b0};
      vecs[7]  = '{1010, 20, 1'b1, 1'b1, 1010, 1'b1, 1'b0};  // upper window edge
      vecs[8]  = '{990,  20, 1'b1, 1'b1, 990,  1'b1, 1'b0};  // lower window edge
      vecs[9]  = '{989,  20, 1'b1, 1'b1, 989,  1'b0, 1'b0};  // just early
      vecs[10] = '{1011, 20, 1'b1, 1'b1, 1011, 1'b0, 1'b0};  // q beats ACQUIRE timeout
      vecs[11] = '{1000, 4,  1'b1, 1'b1, 1000, 1'b0, 1'b0};  // exactly GLITCH wide
      vecs[12] = '{300,  3,  1'b0, 1'b0, 0,    1'b0, 1'b0};  // glitch mid-interval
      vecs[13] = '{700,  20, 1'b1, 1'b1, 1000, 1'b1, 1'b0};

      fork
         forever begin
            @(negedge clk);
            if (!rst) mon_step();
         end
      join_none

      // Reset state
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pps_out",   pps_out,   0);
      check("rst_locked",    locked,    0);
      check("rst_holdover",  holdover,  0);
      check("rst_ivl_valid", ivl_valid, 0);
      check("rst_last_ivl",  last_ivl,  0);
      rst = 1'b0;

      // Table-driven pulse trains
      start = cyc;
      for (int i = 0; i < 14; i++) begin
         start += vecs[i].offset;
         send_pulse(start, vecs[i].width, vecs[i].pulse, vecs[i].valid, vecs[i].ivl);
         wait_cyc(start + LAT + 2);
         check($sformatf("vec%0d_locked", i),   locked,   vecs[i].lck);
         check($sformatf("vec%0d_holdover", i), holdover, vecs[i].hold);
      end

      // Loss of pulse while locked: 1010, then on the 1000 grid, three in all
      q = start + LAT;
      expect_syn(q + NOMINAL + TOL);
      expect_syn(q + 2 * NOMINAL);
      expect_syn(q + 3 * NOMINAL);
      wait_cyc(q + NOMINAL + TOL + 2);
      check("hold1_holdover", holdover, 1);
      check("hold1_locked",   locked,   0);
      wait_cyc(q + 2 * NOMINAL + 2);
      check("hold2_holdover", holdover, 1);
      wait_cyc(q + 3 * NOMINAL + 2);
      check("hold_exit_holdover", holdover, 0);
      check("hold_exit_locked",   locked,   0);
      wait_cyc(q + 4 * NOMINAL + 600);

      // Re-lock, enter holdover, then a real edge on the synthetic cycle
      start = cyc + 10;
      send_pulse(start,               20, 1'b1, 1'b0, 0);
      send_pulse(start + NOMINAL,     20, 1'b1, 1'b1, 1000);
      send_pulse(start + 2 * NOMINAL, 20, 1'b1, 1'b1, 1000);
      q = start + 2 * NOMINAL + LAT;
      wait_cyc(q + 2);
      check("relock_locked", locked, 1);
      expect_syn(q + NOMINAL + TOL);
      wait_cyc(q + NOMINAL + TOL + 2);
      check("coll_pre_holdover", holdover, 1);
      send_pulse(q + 2 * NOMINAL - LAT, 20, 1'b1, 1'b1, 1000);
      wait_cyc(q + 2 * NOMINAL + 2);
      check("coll_holdover", holdover, 0);
      check("coll_locked",   locked,   0);
      send_pulse(q + 3 * NOMINAL - LAT, 20, 1'b1, 1'b1, 1000);
      wait_cyc(q + 3 * NOMINAL + 2);
      check("coll_acq_locked", locked, 0);
      send_pulse(q + 4 * NOMINAL - LAT, 20, 1'b1, 1'b1, 1000);
      q2 = q + 4 * NOMINAL;
      wait_cyc(q2 + 2);
      check("coll_relock", locked, 1);

      // Reset in the middle of holdover
      expect_syn(q2 + NOMINAL + TOL);
      wait_cyc(q2 + 1500);
      check("pre_rst_holdover", holdover, 1);
      #3 rst = 1'b1;
      #1;
      check("midrst_pps_out",   pps_out,   0);
      check("midrst_locked",    locked,    0);
      check("midrst_holdover",  holdover,  0);
      check("midrst_ivl_valid", ivl_valid, 0);
      check("midrst_last_ivl",  last_ivl,  0);
      wait_cyc(q2 + 1505);
      rst = 1'b0;
      wait_cyc(q2 + 3500);
      check("post_rst_holdover", holdover, 0);
      check("post_rst_locked",   locked,   0);
      start = cyc + 10;
      send_pulse(start, 20, 1'b1, 1'b0, 0);
      wait_cyc(start + LAT + 2);
      check("post_rst_last_ivl", last_ivl, 0);
      wait_cyc(cyc + 50);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
